// File: rtl/al_bky_cfg_fetch.sv
// Fetches NWORDS shift-pattern words over a req/ack read port and strobes each into the Buckeye load FIFO.
// Latency: START -> RD_REQ next cycle; at least 4 cycles per word (REQ, WAIT_ACK, PUSH, NEXT).
// Backpressure: FIFO_FULL holds the FSM in REQ with RD_REQ low; a missing RD_ACK times out into TMO_ERR.
module al_bky_cfg_fetch #(
    parameter int NWORDS  = 54,
    parameter int AW      = 23,
    parameter int TMO_CYC = 255
) (
    input  logic          CLK40,
    input  logic          RST_N,
    input  logic          START,
    input  logic          ABORT,
    input  logic [AW-1:0] BASE_ADDR,
    input  logic          FIFO_FULL,
    output logic          RD_REQ,
    output logic [AW-1:0] RD_ADDR,
    input  logic          RD_ACK,
    input  logic [15:0]   RD_DATA,
    output logic [15:0]   BPI_AL_REG,
    output logic          CAPTURE,
    output logic          BUSY,
    output logic          DONE,
    output logic          TMO_ERR,
    output logic [15:0]   CHKSUM,
    output logic [9:0]    WORD_CNT,
    output logic [2:0]    FETCH_STATE
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        REQ      = 3'd1,
        WAIT_ACK = 3'd2,
        PUSH     = 3'd3,
        NEXT     = 3'd4,
        FIN      = 3'd5,
        ERR      = 3'd6
    } state_t;

    localparam logic [9:0] NWORDS_L = 10'(NWORDS);
    localparam logic [7:0] TMO_LAST = 8'(TMO_CYC - 1);

    state_t          state;
    logic [AW-1:0]   base_addr;
    logic [7:0]      timer;

    assign RD_REQ      = (state == REQ) && !FIFO_FULL;
    assign CAPTURE     = (state == PUSH);
    assign BUSY        = (state != IDLE);
    assign FETCH_STATE = state;

    always_ff @(posedge CLK40 or negedge RST_N) begin
        if (!RST_N) begin
            state      <= IDLE;
            base_addr  <= '0;
            RD_ADDR    <= '0;
            BPI_AL_REG <= '0;
            DONE       <= 1'b0;
            TMO_ERR    <= 1'b0;
            CHKSUM     <= '0;
            WORD_CNT   <= '0;
            timer      <= '0;
        end else if (ABORT && state != IDLE) begin
            // Abort drops any in-flight word; counters and checksum keep their partial values.
            state <= IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (START) begin
                        state     <= REQ;
                        base_addr <= BASE_ADDR;
                        RD_ADDR   <= BASE_ADDR;
                        WORD_CNT  <= '0;
                        CHKSUM    <= '0;
                        DONE      <= 1'b0;
                        TMO_ERR   <= 1'b0;
                        timer     <= '0;
                    end
                end
                REQ: begin
                    if (!FIFO_FULL) state <= WAIT_ACK;
                end
                WAIT_ACK: begin
                    timer <= timer + 8'd1;
                    if (RD_ACK) begin
                        state      <= PUSH;
                        BPI_AL_REG <= RD_DATA;
                    end else if (timer == TMO_LAST) begin
                        state <= ERR;
                    end
                end
                PUSH: begin
                    CHKSUM   <= CHKSUM + BPI_AL_REG;
                    WORD_CNT <= WORD_CNT + 10'd1;
                    // Next word address computed here so RD_ADDR is already valid in REQ.
                    RD_ADDR  <= base_addr + AW'(WORD_CNT) + AW'(1);
                    timer    <= '0;
                    state    <= NEXT;
                end
                NEXT: begin
                    state <= (WORD_CNT == NWORDS_L) ? FIN : REQ;
                end
                FIN: begin
                    DONE  <= 1'b1;
                    state <= IDLE;
                end
                ERR: begin
                    TMO_ERR <= 1'b1;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
